// File: rtl/keypad_pkg.sv
// Shared types, key codes and helpers for the keypad operand entry controller.
package keypad_pkg;

  localparam int unsigned KEY_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_OPERAND_A = 3'd1,
    ST_OPERATOR  = 3'd2,
    ST_OPERAND_B = 3'd3,
    ST_ISSUE     = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_MUL  = 2'b10,
    OP_NONE = 2'b11
  } op_sel_t;

  localparam logic [KEY_W-1:0] KEY_ADD = 4'hA;
  localparam logic [KEY_W-1:0] KEY_SUB = 4'hB;
  localparam logic [KEY_W-1:0] KEY_MUL = 4'hC;
  localparam logic [KEY_W-1:0] KEY_CLR = 4'hD;
  localparam logic [KEY_W-1:0] KEY_EQ  = 4'hE;
  localparam logic [KEY_W-1:0] KEY_NOP = 4'hF;

  function automatic logic is_digit(input logic [KEY_W-1:0] code);
    return code <= 4'd9;
  endfunction

  function automatic logic is_op(input logic [KEY_W-1:0] code);
    return (code >= KEY_ADD) && (code <= KEY_MUL);
  endfunction

  function automatic op_sel_t key_to_op(input logic [KEY_W-1:0] code);
    case (code)
      KEY_SUB: return OP_SUB;
      KEY_MUL: return OP_MUL;
      default: return OP_ADD;
    endcase
  endfunction

  // Largest decimal value representable by n digits plus one (10^n).
  function automatic longint unsigned pow10(input int unsigned n);
    longint unsigned v;
    v = 64'd1;
    for (int unsigned i = 0; i < n; i++) v = v * 64'd10;
    return v;
  endfunction

endpackage

// File: rtl/key_edge_detect.sv
// Rising-edge detector for an already-synchronised keypad level.
module key_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic i_level,
  output logic o_pulse_c
);

  logic r_prev;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_prev <= 1'b0;
    else      r_prev <= i_level;
  end

  assign o_pulse_c = i_level & ~r_prev;

endmodule

// File: rtl/keypad_operand_entry.sv
// Keypad entry FSM: builds two decimal operands in binary, latches the operator
// and hands the pair to the arithmetic unit over a valid/ready handshake.
module keypad_operand_entry
  import keypad_pkg::*;
#(
  parameter int unsigned N_DIGITS = 3,
  parameter int unsigned OP_W     = 10
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            key_pressed,
  input  logic [3:0]      key_code,
  input  logic            op_ready,
  output logic            op_valid,
  output logic [OP_W-1:0] operand_a,
  output logic [OP_W-1:0] operand_b,
  output logic [1:0]      op_sel,
  output logic [2:0]      entry_state,
  output logic            digit_err
);

  localparam int unsigned CNT_W = $clog2(N_DIGITS + 1);

  if (N_DIGITS < 1 || (64'd1 << OP_W) <= (pow10(N_DIGITS) - 64'd1)) begin : g_param_check
    $error("keypad_operand_entry: OP_W too narrow for N_DIGITS decimal digits");
  end

  state_t          r_state, w_state_nxt;
  logic [OP_W-1:0] r_a, w_a_nxt, r_b, w_b_nxt;
  logic [OP_W-1:0] w_acc_sel, w_acc_mac, w_digit;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  op_sel_t         r_op, w_op_nxt;
  logic            r_valid, w_valid_nxt;
  logic            r_err, w_err_nxt;
  logic            w_key_ev, w_handshake, w_room;

  key_edge_detect u_key_edge (
    .clk       (clk),
    .rst       (rst),
    .i_level   (key_pressed),
    .o_pulse_c (w_key_ev)
  );

  // One shared x10+d datapath, steered to whichever operand is being entered.
  assign w_acc_sel   = (r_state == ST_OPERAND_B) ? r_b : r_a;
  assign w_digit     = OP_W'(key_code);
  assign w_acc_mac   = (w_acc_sel << 3) + (w_acc_sel << 1) + w_digit;
  assign w_room      = r_cnt < CNT_W'(N_DIGITS);
  assign w_handshake = r_valid & op_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_a_nxt     = r_a;
    w_b_nxt     = r_b;
    w_cnt_nxt   = r_cnt;
    w_op_nxt    = r_op;
    w_err_nxt   = 1'b0;

    if (r_state == ST_ISSUE) begin
      // Operands are frozen here; every real key is rejected, even clear.
      if (w_key_ev && key_code != KEY_NOP) w_err_nxt = 1'b1;
      if (w_handshake) begin
        w_state_nxt = ST_IDLE;
        w_a_nxt     = '0;
        w_b_nxt     = '0;
        w_cnt_nxt   = '0;
        w_op_nxt    = OP_ADD;
      end
    end else if (w_key_ev) begin
      if (key_code == KEY_CLR) begin
        w_state_nxt = ST_IDLE;
        w_a_nxt     = '0;
        w_b_nxt     = '0;
        w_cnt_nxt   = '0;
        w_op_nxt    = OP_ADD;
      end else if (is_digit(key_code)) begin
        case (r_state)
          ST_IDLE: begin
            w_a_nxt     = w_digit;
            w_cnt_nxt   = CNT_W'(1);
            w_state_nxt = ST_OPERAND_A;
          end
          ST_OPERATOR: begin
            w_b_nxt     = w_digit;
            w_cnt_nxt   = CNT_W'(1);
            w_state_nxt = ST_OPERAND_B;
          end
          ST_OPERAND_A: begin
            if (w_room) begin
              w_a_nxt   = w_acc_mac;
              w_cnt_nxt = r_cnt + CNT_W'(1);
            end else begin
              w_err_nxt = 1'b1;
            end
          end
          ST_OPERAND_B: begin
            if (w_room) begin
              w_b_nxt   = w_acc_mac;
              w_cnt_nxt = r_cnt + CNT_W'(1);
            end else begin
              w_err_nxt = 1'b1;
            end
          end
          default: ;
        endcase
      end else if (is_op(key_code)) begin
        case (r_state)
          ST_OPERAND_A: begin
            w_op_nxt    = key_to_op(key_code);
            w_state_nxt = ST_OPERATOR;
          end
          ST_OPERATOR: w_op_nxt = key_to_op(key_code);
          default:     w_err_nxt = 1'b1;
        endcase
      end else if (key_code == KEY_EQ) begin
        if (r_state == ST_OPERAND_B) w_state_nxt = ST_ISSUE;
        else                         w_err_nxt   = 1'b1;
      end
    end

    w_valid_nxt = (w_state_nxt == ST_ISSUE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_cnt   <= '0;
      r_op    <= OP_ADD;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_a     <= w_a_nxt;
      r_b     <= w_b_nxt;
      r_cnt   <= w_cnt_nxt;
      r_op    <= w_op_nxt;
      r_valid <= w_valid_nxt;
      r_err   <= w_err_nxt;
    end
  end

  assign op_valid    = r_valid;
  assign operand_a   = r_a;
  assign operand_b   = r_b;
  assign op_sel      = r_op;
  assign entry_state = r_state;
  assign digit_err   = r_err;

endmodule

// File: tb/tb_keypad_operand_entry.sv
// Scoreboard bench for keypad_operand_entry: directed scenarios plus random key traffic.
`timescale 1ns/1ps
module tb_keypad_operand_entry;

  localparam int N_DIGITS = 3;
  localparam int OP_W     = 10;
  localparam int S_IDLE = 0, S_OPA = 1, S_OPER = 2, S_OPB = 3, S_ISSUE = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            key_pressed = 1'b0;
  logic [3:0]      key_code = 4'h0;
  logic            op_ready = 1'b0;
  logic            op_valid;
  logic [OP_W-1:0] operand_a, operand_b;
  logic [1:0]      op_sel;
  logic [2:0]      entry_state;
  logic            digit_err;

  always #5 clk = ~clk;

  keypad_operand_entry #(.N_DIGITS(N_DIGITS), .OP_W(OP_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .key_pressed (key_pressed),
    .key_code    (key_code),
    .op_ready    (op_ready),
    .op_valid    (op_valid),
    .operand_a   (operand_a),
    .operand_b   (operand_b),
    .op_sel      (op_sel),
    .entry_state (entry_state),
    .digit_err   (digit_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: calculator entry rules on plain integers.
  typedef struct { int a; int b; int op; } txn_t;
  txn_t exp_q[$];
  int m_state = S_IDLE, m_a = 0, m_b = 0, m_cnt = 0, m_op = 0, m_err = 0;
  int err_seen = 0;

  function automatic void model_clear();
    m_state = S_IDLE; m_a = 0; m_b = 0; m_cnt = 0; m_op = 0;
  endfunction

  function automatic void model_key(input int code);
    txn_t t;
    if (m_state == S_ISSUE) begin
      if (code != 15) m_err++;
      return;
    end
    if (code == 15) return;
    if (code == 13) begin model_clear(); return; end
    if (code <= 9) begin
      if (m_state == S_IDLE)      begin m_a = code; m_cnt = 1; m_state = S_OPA; end
      else if (m_state == S_OPER) begin m_b = code; m_cnt = 1; m_state = S_OPB; end
      else if (m_cnt < N_DIGITS) begin
        if (m_state == S_OPA) m_a = m_a * 10 + code;
        else                  m_b = m_b * 10 + code;
        m_cnt++;
      end else m_err++;
    end else if (code <= 12) begin
      if (m_state == S_OPA || m_state == S_OPER) begin m_op = code - 10; m_state = S_OPER; end
      else m_err++;
    end else begin
      if (m_state == S_OPB) begin
        t.a = m_a; t.b = m_b; t.op = m_op;
        exp_q.push_back(t);
        m_state = S_ISSUE;
      end else m_err++;
    end
  endfunction

  // Monitor: counts error pulses, checks hold-stability and each handshake.
  initial begin
    logic            prev_valid;
    logic [OP_W-1:0] pa, pb;
    logic [1:0]      pop;
    txn_t            t;
    prev_valid = 1'b0; pa = '0; pb = '0; pop = '0;
    forever begin
      @(negedge clk);
      if (digit_err === 1'b1) err_seen++;
      if (op_valid === 1'b1 && prev_valid) begin
        check("hold_a", operand_a, pa);
        check("hold_b", operand_b, pb);
        check("hold_op", op_sel, pop);
      end
      if (op_valid === 1'b1 && op_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_issue: got a=%0d b=%0d expected no transfer", operand_a, operand_b);
        end else begin
          t = exp_q.pop_front();
          check("xfer_a", operand_a, t.a);
          check("xfer_b", operand_b, t.b);
          check("xfer_op", op_sel, t.op);
        end
      end
      prev_valid = (op_valid === 1'b1);
      pa = operand_a; pb = operand_b; pop = op_sel;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic press(input int code, input int hold);
    key_code = 4'(code);
    key_pressed = 1'b1;
    model_key(code);
    repeat (hold) tick();
    key_pressed = 1'b0;
    tick();
  endtask

  task automatic check_model(input string tag);
    check({tag, "_state"}, entry_state, m_state);
    check({tag, "_a"}, operand_a, m_a);
    check({tag, "_b"}, operand_b, m_b);
    check({tag, "_op"}, op_sel, m_op);
    check({tag, "_err"}, err_seen, m_err);
    check({tag, "_valid"}, op_valid, (m_state == S_ISSUE) ? 1 : 0);
  endtask

  task automatic finish_issue(input int low_cycles);
    op_ready = 1'b0;
    repeat (low_cycles) begin
      tick();
      check("valid_held", op_valid, 1);
    end
    op_ready = 1'b1;
    tick();
    op_ready = 1'b0;
    model_clear();
    check("after_xfer_valid", op_valid, 0);
    check("after_xfer_state", entry_state, S_IDLE);
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: got timeout expected test completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int r, code;
    // Reset values
    repeat (3) tick();
    check_model("reset");
    rst = 1'b1;
    tick();

    // 123 x 45 with op_ready already high: one-cycle transfer
    press(1, 1); press(2, 1); press(3, 1); press(12, 1); press(4, 1); press(5, 1);
    check_model("t1_entry");
    op_ready = 1'b1;
    key_code = 4'hE; key_pressed = 1'b1; model_key(14);
    tick();
    check("t1_valid_rise", op_valid, 1);
    key_pressed = 1'b0;
    tick();
    model_clear();
    op_ready = 1'b0;
    check("t1_valid_fall", op_valid, 0);
    check_model("t1_idle");

    // Digit overflow then a stalled transfer
    press(9, 1); press(9, 2); press(9, 1); press(9, 1);
    check_model("t2_overflow");
    press(12, 1); press(7, 1); press(14, 1);
    check_model("t2_issue");
    finish_issue(5);
    check_model("t2_done");

    // Operator replacement, then operators/equals rejected in IDLE
    press(5, 1); press(10, 1); press(11, 1); press(2, 1); press(14, 1);
    check_model("t3_issue");
    finish_issue(0);
    press(14, 1); press(10, 1);
    check_model("t3_idle_err");

    // Clear mid-entry, then a long hold yields one digit
    press(8, 1); press(12, 1); press(3, 1); press(13, 1);
    check_model("t4_clear");
    press(6, 10);
    check_model("t4_hold");
    press(13, 1);

    // Key event coinciding with the handshake edge
    press(1, 1); press(10, 1); press(2, 1); press(14, 1);
    check_model("t5_issue");
    op_ready = 1'b1;
    key_code = 4'h7; key_pressed = 1'b1; model_key(7);
    tick();
    model_clear();
    op_ready = 1'b0;
    key_pressed = 1'b0;
    tick();
    check_model("t5_collide");

    // Async reset mid operand B, key already held at release
    press(4, 1); press(11, 1); press(5, 1); press(6, 1);
    check_model("t6_pre");
    #2 rst = 1'b0;
    key_code = 4'h6; key_pressed = 1'b1;
    #1;
    model_clear();
    check_model("t6_async");
    tick();
    rst = 1'b1;
    model_key(6);
    tick();
    key_pressed = 1'b0;
    tick();
    check_model("t6_first_event");
    press(13, 1);

    // Random key traffic
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 99);
      if (r < 55)      code = $urandom_range(0, 9);
      else if (r < 70) code = $urandom_range(10, 12);
      else if (r < 82) code = 14;
      else if (r < 88) code = 13;
      else             code = 15;
      press(code, $urandom_range(1, 3));
      check_model("rand");
      if (m_state == S_ISSUE) begin
        if ($urandom_range(0, 3) == 0) press($urandom_range(0, 15), 1);
        check_model("rand_issue");
        finish_issue($urandom_range(0, 3));
      end
    end

    tick();
    check("final_queue", exp_q.size(), 0);
    check("final_err", err_seen, m_err);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
